seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU for the lab datapath. It extends the 8-bit combinational ALU in three ways: data width is a parameter, the pattern width for string matching is a parameter, and it adds iterative multiply, divide and match-count operations. Operands enter through a start/busy/done handshake. Result and flag are registered and are returned to the register file and flag register by the controller.

## Interface
- WIDTH, default 8: operand and result width; legal range is WIDTH ≥ 2.
- PAT_W, default 4: pattern width for MATCH_CNT; legal range is 1 ≤ PAT_W ≤ WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only when the block is idle or done.
- op  in  4  operation code, sampled when start is accepted.
- a  in  WIDTH  operand A, sampled when start is accepted.
- b  in  WIDTH  operand B, sampled when start is accepted.
- flag_in  in  1  current architectural flag, sampled when start is accepted.
- busy  out  1  high while an iterative operation is running.
- done  out  1  one-cycle pulse; result and flag are valid in that cycle.
- result  out  WIDTH  registered result; holds its value until the next done.
- flag  out  1  registered flag; holds its value until the next done.

## Operation
- FSM states are IDLE, RUN and DONE. The block accepts a request when start=1 and the state is IDLE or DONE, so back-to-back requests are allowed. It latches op, a, b and flag_in at that edge.
- Single-cycle operations go from accept straight to DONE. Iterative operations go from accept to RUN, then to DONE when the iteration counter expires. DONE goes to IDLE unless a new start is accepted in that cycle.
- start is ignored while in RUN. It is not queued.
- Opcodes and results (all arithmetic is modulo 2^WIDTH unless stated):
  - 0 PASS: result=a; flag=flag_in.
  - 1 ABSDIFF: a and b are treated as signed; result=|a−b|, truncated; flag=(a<b) signed.
  - 2 ADDU: {flag,result}=a+b, where flag is the carry out.
  - 3 LSL1: result={a[WIDTH−2:0],flag_in}; flag=a[WIDTH−1].
  - 4 MINU: result is the unsigned minimum of a and b; flag=flag_in.
  - 5 DEC_Z: result=a−1; flag=(a==1).
  - 6 MULU: shift-add multiply, one multiplier bit per cycle, WIDTH iterations. result is the low WIDTH bits of a×b. flag=1 if the high WIDTH bits are nonzero (overflow).
  - 7 MATCH_CNT: tests one window per cycle, for i = 0 … WIDTH−PAT_W, giving WIDTH−PAT_W+1 iterations. A window matches when b[i+PAT_W−1:i] == a[PAT_W−1:0]. result is the number of matches, zero-extended. flag=(count≠0).
  - 8 DIVU: restoring division, WIDTH iterations. result=a/b, unsigned; flag=0.
    - If b==0, result is all ones and flag=1. The operation still takes the full WIDTH iterations.
  - 9–15 reserved: behave exactly as PASS.
- Internal registers for iterative operations:
  - product accumulator, 2·WIDTH bits;
  - remainder, WIDTH+1 bits;
  - quotient/shift register, WIDTH bits;
  - iteration counter, $clog2(WIDTH+1) bits.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, flag=0, and all internal registers are 0.
- Reset asserted in any state, including mid-RUN, abandons the operation. From the next cycle the block shows reset values, and no done pulse is produced for the abandoned operation.
- Latency is counted from the accepting edge N to the cycle in which done=1:
  - PASS, ABSDIFF, ADDU, LSL1, MINU, DEC_Z and reserved: done in cycle N+1; busy stays 0.
  - MULU and DIVU: busy=1 for WIDTH cycles; done in cycle N+WIDTH+1.
  - MATCH_CNT: busy=1 for WIDTH−PAT_W+1 cycles; done in cycle N+WIDTH−PAT_W+2.
- busy and done are never high in the same cycle.
- result and flag change only on the edge that enters DONE. They are stable during RUN and IDLE.
- A start accepted in a DONE cycle begins the new operation at that edge. done for the previous operation still lasts exactly one cycle.
- Operand inputs may change freely after the accepting edge.

## Test plan
All scenarios use WIDTH=8 and PAT_W=4.
- ADDU with a=200, b=100 → result=44, flag=1, done in cycle N+1, busy never 1.
- ABSDIFF with a=0xFB (−5), b=3 → result=8, flag=1. LSL1 with a=0x81, flag_in=1 → result=0x03, flag=1.
- MULU:
  - 13×11 → result=143, flag=0.
  - 16×16 → result=0, flag=1.
  - In both cases busy=1 for exactly 8 cycles and done in cycle N+9.
- MATCH_CNT with a=0x05, b=0x55 → result=3, flag=1, done in cycle N+6.
- DIVU 100/7 → result=14, flag=0. DIVU 9/0 → result=0xFF, flag=1. Both take 9 cycles to done.
- Control and reset behaviour:
  - start pulsed during a MULU RUN is ignored, and the final result is unchanged.
  - reset asserted mid-MULU → the next cycle shows busy=0, done=0, result=0, and no later done.
  - A new ADDU start issued in the DONE cycle of a previous op → a second done one cycle later.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake; single-cycle ops finish at accept, MULU/DIVU/MATCH_CNT iterate.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_N  = CW'(WIDTH);
    localparam logic [CW-1:0] MATCH_N = CW'(WIDTH - PAT_W + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, quo, quo_n, sc_res;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH:0]     rem, rem_n, shifted, sum_ab;
    logic [CW-1:0]      cnt;
    logic               accept, iter, last, fits, match, lt, sc_flag;
    assign accept  = start && state != RUN;
    assign iter    = op == 4'd6 || op == 4'd7 || op == 4'd8;
    assign last    = state == RUN && cnt == CW'(1);
    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign lt      = $signed(a) < $signed(b);
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, b_r};
    assign match   = quo[PAT_W-1:0] == a_r[PAT_W-1:0];
    always_comb begin
        state_n = state;
        if (accept)
            state_n = iter ? RUN : DONE;
        else if (state == DONE)
            state_n = IDLE;
        else if (last)
            state_n = DONE;
    end
    always_comb begin
        sc_res  = a;
        sc_flag = flag_in;
        case (op)
            4'd1: begin sc_res = lt ? b - a : a - b; sc_flag = lt; end
            4'd2: {sc_flag, sc_res} = sum_ab;
            4'd3: begin sc_res = {a[WIDTH-2:0], flag_in}; sc_flag = a[WIDTH-1]; end
            4'd4: sc_res = a < b ? a : b;
            4'd5: begin sc_res = a - WIDTH'(1); sc_flag = a == WIDTH'(1); end
            default: ;
        endcase
    end
    // MULU adds the multiplicand at weight (iteration index); DIVU shifts the dividend out of quo into rem; MATCH_CNT slides b through quo and counts in rem.
    always_comb begin
        prod_n = prod + (quo[0] ? ((2*WIDTH)'(a_r) << (FULL_N - cnt)) : '0);
        quo_n  = op_r == 4'd8 ? {quo[WIDTH-2:0], fits} : quo >> 1;
        rem_n  = op_r == 4'd8 ? (fits ? shifted - {1'b0, b_r} : shifted) : rem + (WIDTH+1)'(match);
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else if (accept) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            prod <= '0;
            rem  <= '0;
            quo  <= op == 4'd8 ? a : b;
            cnt  <= op == 4'd7 ? MATCH_N : FULL_N;
            if (!iter) begin
                result <= sc_res;
                flag   <= sc_flag;
            end
        end else if (state == RUN) begin
            prod <= prod_n;
            rem  <= rem_n;
            quo  <= quo_n;
            cnt  <= cnt - CW'(1);
            if (last) begin
                result <= op_r == 4'd6 ? prod_n[WIDTH-1:0] : op_r == 4'd7 ? rem_n[WIDTH-1:0] : quo_n;
                flag   <= op_r == 4'd6 ? |prod_n[2*WIDTH-1:WIDTH] : op_r == 4'd7 ? |rem_n : b_r == '0;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized + directed scoreboard bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 8;
    localparam int P = 4;
    logic         clk = 0, reset = 1, start = 0, flag_in = 0;
    logic [3:0]   op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic         busy, done, flag;
    logic [W-1:0] result;
    seq_alu #(.WIDTH(W), .PAT_W(P)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flag_in(flag_in),
        .busy(busy), .done(done), .result(result), .flag(flag)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [W-1:0] r;
        logic         f;
        int           lat;
        int           acc;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int total = 0, bad = 0, busy_cnt = 0, zchk_req = 0, zchk_done = 0, tmo = 0, tmo_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic f);
        exp_t   e;
        longint ux = x, uy = y, m = 64'd1 << W, r = 0, p;
        int     sx = $signed(x), sy = $signed(y), n = 0;
        e.f = f;
        e.lat = 1;
        e.acc = 0;
        case (o)
            1: begin r = (sx < sy) ? sy - sx : sx - sy; e.f = sx < sy; end
            2: begin r = ux + uy; e.f = r >= m; end
            3: begin r = ux * 2 + longint'(f); e.f = ux >= m / 2; end
            4: r = ux < uy ? ux : uy;
            5: begin r = ux + m - 1; e.f = ux == 1; end
            6: begin p = ux * uy; r = p; e.f = p >= m; e.lat = W + 1; end
            7: begin
                for (int i = 0; i <= W - P; i++)
                    if (((uy >> i) % (64'd1 << P)) == (ux % (64'd1 << P))) n++;
                r = n; e.f = n != 0; e.lat = W - P + 2;
            end
            8: begin
                if (uy == 0) begin r = m - 1; e.f = 1; end
                else begin r = ux / uy; e.f = 0; end
                e.lat = W + 1;
            end
            default: r = ux;
        endcase
        r = r % m;
        e.r = r[W-1:0];
        return e;
    endfunction
    task automatic chk(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (reset) busy_cnt = 0;
        else begin
            if (zchk_req != zchk_done) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_result", result, 0);
                chk("rst_flag", flag, 0);
                zchk_done = zchk_req;
            end
            if (tmo != tmo_seen) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done, want done within 40 cycles");
                tmo_seen = tmo;
            end
            if (busy || done) chk("busy_done_excl", busy && done, 0);
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with result %0d, want no done", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.r);
                    chk("flag", flag, e.f);
                    chk("latency", cyc - e.acc + 1, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat - 1);
                end
                busy_cnt = 0;
            end
        end
    end
    task automatic issue(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic f, bit push);
        exp_t e;
        start = 1; op = o; a = x; b = y; flag_in = f;
        @(posedge clk);
        #1;
        start = 0; op = 4'($urandom); a = W'($urandom); b = W'($urandom); flag_in = 1'($urandom);
        if (push) begin
            e = model(o, x, y, f);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask
    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        tmo++;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "global timeout");
    end
    initial begin
        logic [3:0]   o;
        logic [W-1:0] x, y;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        zchk_req++;
        @(negedge clk);
        issue(4'd2, 8'd200, 8'd100, 0, 1); wait_done();
        issue(4'd1, 8'hFB, 8'd3, 0, 1);    wait_done();
        issue(4'd3, 8'h81, 8'd0, 1, 1);    wait_done();
        issue(4'd6, 8'd13, 8'd11, 0, 1);   wait_done();
        issue(4'd6, 8'd16, 8'd16, 0, 1);   wait_done();
        issue(4'd7, 8'h05, 8'h55, 0, 1);   wait_done();
        issue(4'd8, 8'd100, 8'd7, 0, 1);   wait_done();
        issue(4'd8, 8'd9, 8'd0, 0, 1);     wait_done();
        issue(4'd6, 8'd13, 8'd11, 0, 1);
        repeat (2) @(negedge clk);
        start = 1; op = 4'd2; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 0;
        wait_done();
        issue(4'd2, 8'd1, 8'd2, 0, 1);     wait_done();
        issue(4'd2, 8'd250, 8'd9, 1, 1);   wait_done();
        repeat (2) @(negedge clk);
        issue(4'd6, 8'd200, 8'd200, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        zchk_req++;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            o = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            issue(o, x, y, 1'($urandom), 1);
            wait_done();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
